// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: scans the object table in horizontal blanking, then arbitrates
// the sprite ROM per pixel. Optional horizontal mirroring is enabled by `define SPRITE_HFLIP_EN.
module sprite_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned N_OBJ    = 8,
    parameter int unsigned K_LINE   = 4,
    parameter int unsigned TILE_W   = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              ObjWe,
    input  logic [2:0]        ObjIdx,
    input  logic [9:0]        ObjX,
    input  logic [9:0]        ObjY,
    input  logic [TILE_W-1:0] ObjTile,
    input  logic              ObjEn,
`ifdef SPRITE_HFLIP_EN
    input  logic              ObjFlipX,
`endif
    output logic [TILE_W+5:0] SprAddr,
    output logic              SprHit,
    output logic [2:0]        SprSlot,
    output logic              LineOverflow
);

    localparam int unsigned CntW = $clog2(K_LINE + 1);
    localparam int unsigned PosW = $clog2(K_LINE);
    localparam logic [9:0] HAct = 10'(H_ACTIVE);
    localparam logic [9:0] LastY = 10'(V_TOTAL - 1);
    localparam logic [2:0] LastIdx = 3'(N_OBJ - 1);
    localparam logic [CntW-1:0] KMax = CntW'(K_LINE);

    typedef struct packed {
        logic [2:0]        slot;
        logic [9:0]        x;
        logic [TILE_W-1:0] tile;
        logic [2:0]        row;
`ifdef SPRITE_HFLIP_EN
        logic              flip;
`endif
    } entry_t;

    typedef enum logic [1:0] {StWaitHb, StScan, StDone} state_e;

    logic [9:0]        obj_x_q    [N_OBJ];
    logic [9:0]        obj_y_q    [N_OBJ];
    logic [TILE_W-1:0] obj_tile_q [N_OBJ];
    logic              obj_en_q   [N_OBJ];
`ifdef SPRITE_HFLIP_EN
    logic              obj_flip_q [N_OBJ];
`endif

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    entry_t            pend_q [K_LINE];
    entry_t            pend_d [K_LINE];
    logic [CntW-1:0]   pend_cnt_q, pend_cnt_d;
    logic              pend_ovf_q, pend_ovf_d;
    entry_t            act_q [K_LINE];
    entry_t            act_d [K_LINE];
    logic [CntW-1:0]   act_cnt_q, act_cnt_d;
    logic              line_ovf_q, line_ovf_d;

    logic [9:0]        next_y, scan_dy;
    logic              scan_hit, commit;
    entry_t            scan_ent;
    entry_t            eff_list [K_LINE];
    logic [CntW-1:0]   eff_cnt;
    logic [9:0]        px_dx;
    logic [2:0]        px_col;
    logic              hit_d, hit_q;
    logic [2:0]        slot_d, slot_q;
    logic [TILE_W+5:0] addr_d, addr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                obj_x_q[i]    <= '0;
                obj_y_q[i]    <= '0;
                obj_tile_q[i] <= '0;
                obj_en_q[i]   <= 1'b0;
`ifdef SPRITE_HFLIP_EN
                obj_flip_q[i] <= 1'b0;
`endif
            end
        end else if (ObjWe) begin
            obj_x_q[ObjIdx]    <= ObjX;
            obj_y_q[ObjIdx]    <= ObjY;
            obj_tile_q[ObjIdx] <= ObjTile;
            obj_en_q[ObjIdx]   <= ObjEn;
`ifdef SPRITE_HFLIP_EN
            obj_flip_q[ObjIdx] <= ObjFlipX;
`endif
        end
    end

    assign next_y   = (DrawY == LastY) ? 10'd0 : DrawY + 10'd1;
    assign scan_dy  = next_y - obj_y_q[idx_q];
    assign scan_hit = obj_en_q[idx_q] && (scan_dy < 10'd8);
    assign commit   = (state_q == StDone) && (DrawX == 10'd0);

    always_comb begin
        scan_ent      = '0;
        scan_ent.slot = idx_q;
        scan_ent.x    = obj_x_q[idx_q];
        scan_ent.tile = obj_tile_q[idx_q];
        scan_ent.row  = scan_dy[2:0];
`ifdef SPRITE_HFLIP_EN
        scan_ent.flip = obj_flip_q[idx_q];
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        pend_ovf_d = pend_ovf_q;
        act_d      = act_q;
        act_cnt_d  = act_cnt_q;
        line_ovf_d = line_ovf_q;
        case (state_q)
            StWaitHb: begin
                if (DrawX == HAct) begin
                    state_d    = StScan;
                    idx_d      = 3'd0;
                    pend_cnt_d = '0;
                    pend_ovf_d = 1'b0;
                end
            end
            StScan: begin
                if (scan_hit) begin
                    if (pend_cnt_q < KMax) begin
                        pend_d[pend_cnt_q[PosW-1:0]] = scan_ent;
                        pend_cnt_d = pend_cnt_q + CntW'(1);
                    end else begin
                        pend_ovf_d = 1'b1;
                    end
                end
                if (idx_q == LastIdx) state_d = StDone;
                else                  idx_d   = idx_q + 3'd1;
            end
            StDone: begin
                if (commit) begin
                    act_d      = pend_q;
                    act_cnt_d  = pend_cnt_q;
                    line_ovf_d = pend_ovf_q;
                    state_d    = StWaitHb;
                end
            end
            default: state_d = StWaitHb;
        endcase
    end

    // The committing list is forwarded so pixel 0 of the new line already uses it.
    always_comb begin
        for (int i = 0; i < K_LINE; i++) eff_list[i] = commit ? pend_q[i] : act_q[i];
        eff_cnt = commit ? pend_cnt_q : act_cnt_q;
    end

    // Walk from the last position down so the lowest list position wins.
    always_comb begin
        hit_d  = 1'b0;
        slot_d = '0;
        addr_d = '0;
        px_dx  = '0;
        px_col = '0;
        for (int i = K_LINE - 1; i >= 0; i--) begin
            px_dx = DrawX - eff_list[i].x;
            if ((CntW'(i) < eff_cnt) && (px_dx < 10'd8)) begin
                px_col = px_dx[2:0];
`ifdef SPRITE_HFLIP_EN
                if (eff_list[i].flip) px_col = ~px_dx[2:0];
`endif
                hit_d  = 1'b1;
                slot_d = eff_list[i].slot;
                addr_d = {eff_list[i].tile, eff_list[i].row, px_col};
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StWaitHb;
            idx_q      <= '0;
            pend_cnt_q <= '0;
            pend_ovf_q <= 1'b0;
            act_cnt_q  <= '0;
            line_ovf_q <= 1'b0;
            for (int i = 0; i < K_LINE; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            hit_q      <= 1'b0;
            slot_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_cnt_q <= pend_cnt_d;
            pend_ovf_q <= pend_ovf_d;
            act_cnt_q  <= act_cnt_d;
            line_ovf_q <= line_ovf_d;
            for (int i = 0; i < K_LINE; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
            end
            hit_q      <= hit_d;
            slot_q     <= slot_d;
            addr_q     <= addr_d;
        end
    end

    assign SprAddr      = addr_q;
    assign SprHit       = hit_q;
    assign SprSlot      = slot_q;
    assign LineOverflow = line_ovf_q;

endmodule
